// File: rtl/snake_head_mover_pkg.sv
// Shared encodings and head arithmetic for the snake head mover.
// Head is packed as {row[2:0], col[2:0]} on an 8x8 field.
package snake_head_mover_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HIT  = 2'b10
    } state_e;

    localparam int ROW_MSB = 5;
    localparam int ROW_LSB = 3;
    localparam int COL_MSB = 2;
    localparam int COL_LSB = 0;

    // One cell in the given direction; fields wrap mod 8.
    function automatic logic [5:0] head_step(input logic [5:0] h, input logic [1:0] d);
        logic [2:0] row;
        logic [2:0] col;
        row = h[ROW_MSB:ROW_LSB];
        col = h[COL_MSB:COL_LSB];
        unique case (d)
            DIR_RIGHT: col = col + 3'd1;
            DIR_LEFT:  col = col - 3'd1;
            DIR_DOWN:  row = row + 3'd1;
            DIR_UP:    row = row - 3'd1;
            default:   row = row;
        endcase
        return {row, col};
    endfunction

endpackage

// File: rtl/snake_head_mover_move_timer.sv
// Move-period counter; tc pulses on the last cycle of each period while enabled.
module snake_head_mover_move_timer #(
    parameter int unsigned MOVE_PERIOD = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tc
);

    localparam int unsigned CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOVE_PERIOD - 1);

    logic [CW-1:0] count_q, count_d;

    assign tc = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tc ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/snake_head_mover.sv
// Snake head position/direction with reversal-safe steering and wall-hit freeze.
module snake_head_mover
    import snake_head_mover_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD = 25000000,
    parameter logic [5:0]  INIT_HEAD   = 6'b011_011,
    parameter logic [1:0]  INIT_DIR    = 2'b00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic       colide,
    output logic [5:0] head,
    output logic [1:0] direction,
    output logic       running,
    output logic       game_over,
    output logic       step
);

    state_e     state_q, state_d;
    logic [5:0] head_q, head_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] last_q, last_d;
    logic       step_q, step_d;
    logic       tick;
    logic [1:0] cand;
    logic       req_ok;

    snake_head_mover_move_timer #(
        .MOVE_PERIOD(MOVE_PERIOD)
    ) u_move_timer (
        .clock (clock),
        .reset (reset),
        .enable(state_q == RUN),
        .clear (state_q != RUN),
        .tc    (tick)
    );

    // Priority up > down > left > right.
    always_comb begin
        if (btn[3]) begin
            cand = DIR_UP;
        end else if (btn[2]) begin
            cand = DIR_DOWN;
        end else if (btn[1]) begin
            cand = DIR_LEFT;
        end else begin
            cand = DIR_RIGHT;
        end
    end

    // Reversal is judged against the last direction actually moved, not the pending one.
    assign req_ok = (state_q == RUN) && (|btn) && (cand != (last_q ^ 2'b10));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (tick && colide) state_d = HIT;
            HIT:     if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running   = (state_q == RUN);
        game_over = (state_q == HIT);
    end

    always_comb begin
        head_d = head_q;
        dir_d  = dir_q;
        last_d = last_q;
        step_d = 1'b0;
        if (req_ok) begin
            dir_d = cand;
        end
        // The move uses the direction held during the period, not one requested this cycle.
        if ((state_q == RUN) && tick && !colide) begin
            head_d = head_step(head_q, dir_q);
            last_d = dir_q;
            step_d = 1'b1;
        end
        if ((state_q == HIT) && start) begin
            head_d = INIT_HEAD;
            dir_d  = INIT_DIR;
            last_d = INIT_DIR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= INIT_HEAD;
            dir_q  <= INIT_DIR;
            last_q <= INIT_DIR;
            step_q <= 1'b0;
        end else begin
            head_q <= head_d;
            dir_q  <= dir_d;
            last_q <= last_d;
            step_q <= step_d;
        end
    end

    assign head      = head_q;
    assign direction = dir_q;
    assign step      = step_q;

endmodule
